// File: rtl/key_write_queue.sv
// Key-event FIFO feeding the colour register bank during VGA blanking, with a per-cell colour shadow table.
// Optional build macro KEYQ_COALESCE_EN: drop a strobe that repeats the newest still-queued cell.
module key_write_queue #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] key_pos,
  input  logic              key_stb,
  input  logic              blank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CELLS = 2 ** ADDR_W;

  logic [ADDR_W-1:0] fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_r;
  logic              empty_r;
  logic              overflow_r;
  logic [DATA_W-1:0] colour_r [CELLS];
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  logic              pop_s;
  logic              dup_s;
  logic              push_req_s;
  logic              push_s;
  logic              drop_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [ADDR_W-1:0] head_pos_s;
  logic [DATA_W-1:0] colour_nxt_s;
`ifdef KEYQ_COALESCE_EN
  logic [ADDR_W-1:0] last_pos_s;
`endif

  // Push/pop arbitration and next occupancy
  always_comb begin
    pop_s        = 1'b0;
    dup_s        = 1'b0;
    push_req_s   = 1'b0;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    count_nxt_s  = count_r;
    head_pos_s   = fifo_mem_r[head_r];
    colour_nxt_s = colour_r[head_pos_s] + DATA_W'(1);
`ifdef KEYQ_COALESCE_EN
    last_pos_s   = fifo_mem_r[tail_r - PTR_W'(1)];
    // newest entry sits just behind the tail while the FIFO is non-empty
    if (!empty_r && (last_pos_s == key_pos)) begin
      dup_s = 1'b1;
    end else begin
      dup_s = 1'b0;
    end
`endif
    if (!empty_r && blank) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    push_req_s = key_stb && !dup_s;
    // a full FIFO still accepts a push when the same edge frees a slot
    if (push_req_s && (!full_r || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (push_req_s && full_r && !pop_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy flags and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= {ADDR_W{1'b0}};
      end
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[tail_r] <= key_pos;
        tail_r             <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == CNT_W'(0));
    end
  end

  // Colour shadow table and register-bank write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CELLS; i++) begin
        colour_r[i] <= {DATA_W{1'b0}};
      end
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
    end else begin
      wr_en_r <= pop_s;
      if (pop_s) begin
        colour_r[head_pos_s] <= colour_nxt_s;
        wr_addr_r            <= head_pos_s;
        wr_data_r            <= colour_nxt_s;
      end
    end
  end

  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_key_write_queue.sv
// Randomised plus directed bench for key_write_queue; reference model is a position queue and colour array.
module tb_key_write_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_pos = 4'd0;
  logic       key_stb = 1'b0;
  logic       blank = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
  logic       full;
  logic       empty;
  logic       overflow;

  int n_checks = 0;
  int n_fails  = 0;

  int mq[$];
  int col[16];
  bit movf = 1'b0;
  int exp_addr[$];
  int exp_data[$];

  key_write_queue dut (
    .clk(clk), .rst(rst), .key_pos(key_pos), .key_stb(key_stb), .blank(blank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and advance the reference model at the clock edge.
  task automatic step(input bit stb, input int pos, input bit blk);
    int pre;
    bit do_pop;
    bit dup;
    int p;
    @(negedge clk);
    #1;
    key_stb = stb;
    key_pos = pos[3:0];
    blank   = blk;
    @(posedge clk);
    pre    = mq.size();
    do_pop = blk && (pre > 0);
    dup    = 1'b0;
`ifdef KEYQ_COALESCE_EN
    if (stb && pre > 0 && mq[pre-1] == pos) dup = 1'b1;
`endif
    if (do_pop) begin
      p = mq.pop_front();
      col[p] = (col[p] + 1) % 8;
      exp_addr.push_back(p);
      exp_data.push_back(col[p]);
    end
    if (stb && !dup) begin
      if (pre < 4 || do_pop) mq.push_back(pos);
      else movf = 1'b1;
    end
  endtask

  // Reset shortly after the edge just stepped, discarding anything in flight.
  task automatic do_reset();
    #2;
    rst     = 1'b0;
    key_stb = 1'b0;
    blank   = 1'b0;
    mq.delete();
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < 16; i++) col[i] = 0;
    movf = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compare every write and the status flags against the model.
  always @(negedge clk) begin
    int a;
    int d;
    if (!rst) begin
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_overflow", overflow, 0);
    end else begin
      if (wr_en) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          a = exp_addr.pop_front();
          d = exp_data.pop_front();
          chk("wr_addr", wr_addr, a);
          chk("wr_data", wr_data, d);
        end
      end else if (exp_addr.size() > 0) begin
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        chk("missing_write", 0, 1);
      end
      chk("full", full, (mq.size() == 4) ? 1 : 0);
      chk("empty", empty, (mq.size() == 0) ? 1 : 0);
      chk("overflow", overflow, movf ? 1 : 0);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    // single event held until blanking
    step(1'b1, 5, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // colour wrap on one cell
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2, 1'b1);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
    end

    // overflow then full drain
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, i, 1'b0);
    step(1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);

    // push on a pop edge while full
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 10 + i, 1'b0);
    step(1'b1, 9, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1);

    // reset mid-drain
    do_reset();
    step(1'b1, 7, 1'b0);
    step(1'b1, 8, 1'b0);
    step(1'b0, 0, 1'b1);
    do_reset();
    step(1'b1, 7, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // same cell strobed twice while queued
    do_reset();
    step(1'b1, 3, 1'b0);
    step(1'b1, 3, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);

    // randomised traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit stb;
      bit blk;
      int pos;
      stb = ($urandom_range(0, 99) < 60);
      blk = ($urandom_range(0, 99) < 40);
      pos = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      step(stb, pos, blk);
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);

    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
